// File: rtl/amber_wb_feeder.sv
// Feeds a Wishbone instruction/data read port from an instruction FIFO and a
// load-data holding register, and captures core writes. `WB_WAIT_STATE_EN adds wb_stall.
module amber_wb_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int LOAD_LAT   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  input  logic [31:0] inst_data,
  output logic        inst_ready,
  input  logic        data_valid,
  input  logic [31:0] data_in,
  output logic        data_ready,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_w,
`ifdef WB_WAIT_STATE_EN
  input  logic        wb_stall,
`endif
  output logic [31:0] wb_dat_r,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        store_valid,
  output logic [31:0] store_adr,
  output logic [31:0] store_dat,
  output logic [3:0]  store_sel,
  output logic [15:0] fetch_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [31:0] LOAD_MASK = 32'hFDB8_8000;
  localparam logic [31:0] LOAD_VAL  = 32'hE590_0000;
  localparam logic [31:0] SWAP_MASK = 32'hFFB8_8FF8;
  localparam logic [31:0] SWAP_VAL  = 32'hE100_0090;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_ACK  = 2'd1,
    LOAD_WAIT = 2'd2,
    DATA_ACK  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              data_vld_q, data_vld_d;
  logic [31:0]       data_reg_q, data_reg_d;
  logic [2:0]        cd_q, cd_d;
  logic              pend_q, pend_d;
  logic              wb_ack_q, wb_ack_d;
  logic [31:0]       wb_dat_r_q, wb_dat_r_d;
  logic              store_valid_q, store_valid_d;
  logic [31:0]       store_adr_q, store_adr_d;
  logic [31:0]       store_dat_q, store_dat_d;
  logic [3:0]        store_sel_q, store_sel_d;
  logic [15:0]       fetch_cnt_q, fetch_cnt_d;

  logic        full, empty, push, pop, consume, data_push, serve_en;
  logic        rd_req, wr_req, data_due, head_is_mem;
  logic [31:0] head;

  function automatic logic is_load_or_swap(input logic [31:0] w);
    return ((w & LOAD_MASK) == LOAD_VAL) || ((w & SWAP_MASK) == SWAP_VAL);
  endfunction

`ifdef WB_WAIT_STATE_EN
  assign serve_en = !wb_stall;
`else
  assign serve_en = 1'b1;
`endif

  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign push        = inst_valid && !full;
  assign head        = fifo_mem[rd_ptr_q];
  assign head_is_mem = is_load_or_swap(head);
  assign data_push   = data_valid && !data_vld_q;
  assign rd_req      = wb_cyc && wb_stb && !wb_we && serve_en;
  assign wr_req      = wb_cyc && wb_stb && wb_we && serve_en;
  // Countdown exhausted while a load is outstanding: the next read gets load data.
  assign data_due    = pend_q && (cd_q == '0);

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    consume       = 1'b0;
    wb_ack_d      = 1'b0;
    wb_dat_r_d    = wb_dat_r_q;
    store_valid_d = 1'b0;
    store_adr_d   = store_adr_q;
    store_dat_d   = store_dat_q;
    store_sel_d   = store_sel_q;
    fetch_cnt_d   = fetch_cnt_q;
    cd_d          = cd_q;
    pend_d        = pend_q;
    case (state_q)
      IDLE, LOAD_WAIT: begin
        if (wr_req) begin
          store_valid_d = 1'b1;
          store_adr_d   = wb_adr;
          store_dat_d   = wb_dat_w;
          store_sel_d   = wb_sel;
          wb_ack_d      = 1'b1;
          state_d       = INST_ACK;
        end else if (rd_req) begin
          if (data_due) begin
            if (data_vld_q) begin
              consume    = 1'b1;
              wb_dat_r_d = data_reg_q;
              wb_ack_d   = 1'b1;
              pend_d     = 1'b0;
              state_d    = DATA_ACK;
            end
          end else if (!empty) begin
            pop         = 1'b1;
            wb_dat_r_d  = head;
            wb_ack_d    = 1'b1;
            fetch_cnt_d = fetch_cnt_q + 16'd1;
            state_d     = INST_ACK;
            if (head_is_mem) begin
              cd_d   = 3'(LOAD_LAT);
              pend_d = 1'b1;
            end else if (pend_q) begin
              cd_d = cd_q - 3'd1;
            end
          end
        end
      end
      // Ack cycles never serve, so back-to-back acks cannot happen.
      INST_ACK: state_d = pend_q ? LOAD_WAIT : IDLE;
      DATA_ACK: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    data_vld_d = data_vld_q;
    data_reg_d = data_reg_q;
    if (consume) data_vld_d = 1'b0;
    if (data_push) begin
      data_vld_d = 1'b1;
      data_reg_d = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      data_vld_q    <= 1'b0;
      cd_q          <= '0;
      pend_q        <= 1'b0;
      wb_ack_q      <= 1'b0;
      wb_dat_r_q    <= '0;
      store_valid_q <= 1'b0;
      store_adr_q   <= '0;
      store_dat_q   <= '0;
      store_sel_q   <= '0;
      fetch_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      data_vld_q    <= data_vld_d;
      cd_q          <= cd_d;
      pend_q        <= pend_d;
      wb_ack_q      <= wb_ack_d;
      wb_dat_r_q    <= wb_dat_r_d;
      store_valid_q <= store_valid_d;
      store_adr_q   <= store_adr_d;
      store_dat_q   <= store_dat_d;
      store_sel_q   <= store_sel_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  // Storage only; validity lives in the pointers and data_vld_q.
  always_ff @(posedge clk) begin
    data_reg_q <= data_reg_d;
    if (push && !reset) fifo_mem[wr_ptr_q] <= inst_data;
  end

  assign inst_ready  = !full;
  assign data_ready  = !data_vld_q;
  assign wb_dat_r    = wb_dat_r_q;
  assign wb_ack      = wb_ack_q;
  assign wb_err      = 1'b0;
  assign store_valid = store_valid_q;
  assign store_adr   = store_adr_q;
  assign store_dat   = store_dat_q;
  assign store_sel   = store_sel_q;
  assign fetch_cnt   = fetch_cnt_q;

endmodule
